// File: rtl/dmem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared dmem port.
// slave: the arbiter's view; master: the requesters plus memory driving it.
interface dmem_port_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = 32
);
  localparam int unsigned MW = XLEN / 8;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_addr;
  logic [NREQ*MW-1:0]   req_wmask;
  logic [NREQ*XLEN-1:0] req_wdata;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [XLEN-1:0]      mem_addr;
  logic [MW-1:0]        mem_wmask;
  logic [XLEN-1:0]      mem_wdata;
  logic                 mem_rvalid;
  logic [XLEN-1:0]      mem_rdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [XLEN-1:0]      rsp_rdata;
  logic                 err;

  modport slave (
    input  req_valid, req_addr, req_wmask, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_addr, mem_wmask, mem_wdata,
    output rsp_valid, rsp_rdata, err
  );

  modport master (
    output req_valid, req_addr, req_wmask, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_addr, mem_wmask, mem_wdata,
    input  rsp_valid, rsp_rdata, err
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one dmem port among NREQ requesters; an in-order
// ID FIFO of outstanding requests routes each memory response to its owner.
module dmem_port_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic           clock,
  input logic           reset,
  dmem_port_arbiter_if.slave bus
);
  localparam int unsigned MW = XLEN / 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  win_q, win_d;
  logic            mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [MW-1:0]   mem_wmask_q, mem_wmask_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [IDW-1:0]  fifo_q [DEPTH];
  logic [IDW-1:0]  fifo_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] req_ready_c;
  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  int unsigned     scan_idx;
  logic            push;
  logic            pop;
  logic [IDW-1:0]  head_id;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = (32'(rr_ptr_q) + i) % NREQ;
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q;
    req_ready_c = '0;
    push        = 1'b0;
    pop         = 1'b0;
    head_id     = '0;

    case (state_q)
      S_IDLE: begin
        if (!reset && grant_found && (count_q < CW'(DEPTH))) begin
          req_ready_c = NREQ'(1) << grant_id;
          mem_addr_d  = bus.req_addr[32'(grant_id)*XLEN +: XLEN];
          mem_wmask_d = bus.req_wmask[32'(grant_id)*MW +: MW];
          mem_wdata_d = bus.req_wdata[32'(grant_id)*XLEN +: XLEN];
          win_d       = grant_id;
          mem_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.mem_ready) begin
          push        = 1'b1;
          mem_valid_d = 1'b0;
          rr_ptr_d    = (win_q == IDW'(NREQ - 1)) ? '0 : IDW'(win_q + 1'b1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Push is ordered before pop: an empty FIFO with a same-cycle push pops the new ID
    head_id = (count_q == '0) ? win_q : fifo_q[rd_ptr_q];
    pop     = bus.mem_rvalid && ((count_q != '0) || push);

    if (push) begin
      fifo_d[wr_ptr_q] = win_q;
      wr_ptr_d         = AW'(wr_ptr_q + 1'b1);
    end
    if (pop) begin
      rd_ptr_d    = AW'(rd_ptr_q + 1'b1);
      rsp_valid_d = NREQ'(1) << head_id;
      rsp_rdata_d = bus.mem_rdata;
    end
    if (bus.mem_rvalid && !pop) begin
      err_d = 1'b1;
    end
    count_d = CW'(count_q + CW'(push) - CW'(pop));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with NREQ=2, XLEN=32, DEPTH=4.
module tb_dmem_port_arbiter;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dmem_port_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  dmem_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .DEPTH(DEPTH), .IDW(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.req_wmask  = '0;
    bus.req_wdata  = '0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [31:0] addr, input logic [3:0] wm, input logic [31:0] wd);
    bus.req_addr[k*XLEN +: XLEN] = addr;
    bus.req_wmask[k*4 +: 4]      = wm;
    bus.req_wdata[k*XLEN +: XLEN] = wd;
  endtask

  // One full grant/accept handshake for requester k with mem_ready high
  task automatic issue_one(input int k);
    logic [1:0] exp;
    exp = 2'(1) << k;
    bus.req_valid = exp;
    settle();
    checks++; if (bus.req_ready !== exp) begin errors++; $display("FAIL issue_ready got %b exp %b", bus.req_ready, exp); end
    tick();
    bus.req_valid = '0;
    settle();
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL issue_mem_valid got %b exp 1", bus.mem_valid); end
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    bus.req_valid = 2'b11;
    tick();
    settle();
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", bus.req_ready); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %b exp 0", bus.mem_valid); end
    checks++; if ({bus.mem_addr, bus.mem_wmask, bus.mem_wdata} !== 68'h0) begin errors++; $display("FAIL rst_mem_bus got %h exp 0", {bus.mem_addr, bus.mem_wmask, bus.mem_wdata}); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b exp 00", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata got %h exp 0", bus.rsp_rdata); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.err); end
    do_reset();
  endtask

  task automatic test_single_read;
    do_reset();
    set_req(0, 32'h100, 4'h0, 32'h0);
    bus.req_valid = 2'b01;
    settle();
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL sr_req_ready got %b exp 01", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    settle();
    checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL sr_mem got v=%b a=%h exp v=1 a=100", bus.mem_valid, bus.mem_addr); end
    checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL sr_wmask got %h exp 0", bus.mem_wmask); end
    tick();
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL sr_mem_drop got %b exp 0", bus.mem_valid); end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    settle();
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL sr_rsp_valid got %b exp 01", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rsp_rdata got %h exp deadbeef", bus.rsp_rdata); end
    tick();
    checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rsp_hold got v=%b d=%h exp v=00 d=deadbeef", bus.rsp_valid, bus.rsp_rdata); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL sr_err got %b exp 0", bus.err); end
  endtask

  // Both requesters held valid; each accept also gets a same-cycle response
  task automatic test_round_robin;
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_addr;
    do_reset();
    set_req(0, 32'h1000, 4'h0, 32'h0);
    set_req(1, 32'h2000, 4'h0, 32'h0);
    bus.req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_rdy  = (g % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (g % 2 == 0) ? 32'h1000 : 32'h2000;
      settle();
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", g, bus.req_ready, exp_rdy); end
      if (g > 0) begin
        exp_rsp = ((g - 1) % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (bus.rsp_valid !== exp_rsp || bus.rsp_rdata !== 32'hC0 + 32'(g - 1)) begin errors++; $display("FAIL rr_rsp%0d got v=%b d=%h exp v=%b d=%h", g - 1, bus.rsp_valid, bus.rsp_rdata, exp_rsp, 32'hC0 + 32'(g - 1)); end
      end
      tick();
      checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== exp_addr) begin errors++; $display("FAIL rr_addr%0d got v=%b a=%h exp v=1 a=%h", g, bus.mem_valid, bus.mem_addr, exp_addr); end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hC0 + 32'(g);
      tick();
      bus.mem_rvalid = 1'b0;
    end
    bus.req_valid = '0;
    settle();
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'hC3) begin errors++; $display("FAIL rr_rsp3 got v=%b d=%h exp v=10 d=c3", bus.rsp_valid, bus.rsp_rdata); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rr_err got %b exp 0", bus.err); end
  endtask

  task automatic test_backpressure;
    do_reset();
    set_req(1, 32'h200, 4'hF, 32'h11112222);
    bus.mem_ready = 1'b0;
    bus.req_valid = 2'b10;
    settle();
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant got %b exp 10", bus.req_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      set_req(1, 32'h300 + 32'(i), 4'h3, 32'h0 + 32'(i));
      settle();
      checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_wmask !== 4'hF || bus.mem_wdata !== 32'h11112222) begin errors++; $display("FAIL bp_hold%0d got v=%b a=%h m=%h d=%h exp v=1 a=200 m=f d=11112222", i, bus.mem_valid, bus.mem_addr, bus.mem_wmask, bus.mem_wdata); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b exp 00", i, bus.req_ready); end
      tick();
    end
    bus.mem_ready = 1'b1;
    bus.req_valid = '0;
    tick();
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", bus.mem_valid); end
  endtask

  task automatic test_fifo_full;
    do_reset();
    set_req(0, 32'h400, 4'h0, 32'h0);
    set_req(1, 32'h500, 4'h0, 32'h0);
    issue_one(0);
    issue_one(1);
    issue_one(0);
    issue_one(1);
    bus.req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (bus.req_ready !== 2'b00 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL full_block%0d got r=%b v=%b exp r=00 v=0", i, bus.req_ready, bus.mem_valid); end
      tick();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55;
    settle();
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL full_pop_cycle got %b exp 00", bus.req_ready); end
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'h55) begin errors++; $display("FAIL full_rsp got v=%b d=%h exp v=01 d=55", bus.rsp_valid, bus.rsp_rdata); end
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL full_regrant got %b exp 01", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    settle();
    checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h400) begin errors++; $display("FAIL full_issue got v=%b a=%h exp v=1 a=400", bus.mem_valid, bus.mem_addr); end
    tick();
  endtask

  task automatic test_ordering;
    do_reset();
    issue_one(1);
    issue_one(0);
    issue_one(1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hA;
    tick();
    bus.mem_rdata = 32'hB;
    settle();
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'hA) begin errors++; $display("FAIL ord_rsp0 got v=%b d=%h exp v=10 d=a", bus.rsp_valid, bus.rsp_rdata); end
    tick();
    bus.mem_rdata = 32'hC;
    settle();
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'hB) begin errors++; $display("FAIL ord_rsp1 got v=%b d=%h exp v=01 d=b", bus.rsp_valid, bus.rsp_rdata); end
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'hC) begin errors++; $display("FAIL ord_rsp2 got v=%b d=%h exp v=10 d=c", bus.rsp_valid, bus.rsp_rdata); end
    tick();
    checks++; if (bus.rsp_valid !== 2'b00 || bus.err !== 1'b0) begin errors++; $display("FAIL ord_idle got v=%b e=%b exp v=00 e=0", bus.rsp_valid, bus.err); end
  endtask

  task automatic test_error_reset;
    do_reset();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h99;
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    checks++; if (bus.err !== 1'b1 || bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL err_set got e=%b v=%b exp e=1 v=00", bus.err, bus.rsp_valid); end
    tick();
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bus.err); end
    issue_one(0);
    bus.mem_ready = 1'b0;
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = '0;
    settle();
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL err_issue got %b exp 1", bus.mem_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    settle();
    checks++; if (bus.mem_valid !== 1'b0 || bus.err !== 1'b0 || bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL err_reset got v=%b e=%b r=%b exp v=0 e=0 r=00", bus.mem_valid, bus.err, bus.rsp_valid); end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h77;
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    checks++; if (bus.err !== 1'b1 || bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL err_stale_rsp got e=%b v=%b exp e=1 v=00", bus.err, bus.rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_ordering();
    test_error_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
